// File: rtl/cipher_store_pkg.sv
// Shared types and helpers for the nibble cipher-and-store datapath.
// CSC_READBACK_EN (optional) adds an arbitrated readback port to the store.
package cipher_store_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int PROD_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        MUL,
        WR
    } state_e;

    // sel=0: rotate left by 1, sel=1: rotate left by 2
    function automatic logic [DATA_W_DEF-1:0] rotl_sel(
        input logic [DATA_W_DEF-1:0] n,
        input logic                  sel
    );
        logic [DATA_W_DEF-1:0] r;
        if (sel) begin
            r = {n[DATA_W_DEF-3:0], n[DATA_W_DEF-1:DATA_W_DEF-2]};
        end else begin
            r = {n[DATA_W_DEF-2:0], n[DATA_W_DEF-1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/cipher_store_mem.sv
// Store register file: async clear, one write port, a combinational peek port
// and, with CSC_READBACK_EN, one registered read port.
module cipher_store_mem
    import cipher_store_pkg::*;
#(
    parameter int AW = DATA_W_DEF,
    parameter int DW = PROD_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] obs_addr_i,
    output logic [DW-1:0] obs_data_o
`ifdef CSC_READBACK_EN
    ,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
`endif
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign obs_data_o = mem_q[obs_addr_i];

`ifdef CSC_READBACK_EN
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`endif

endmodule

// File: rtl/cipher_store_ctrl.sv
// Sequencer: latch (num,key), rotate, multiply, write store[num], report.
// CSC_READBACK_EN adds the rd_* readback port (writes win over reads).
module cipher_store_ctrl
    import cipher_store_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] num,
    input  logic [DATA_W-1:0] key,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_addr,
    output logic [PROD_W-1:0] out_data,
    output logic [CNT_W-1:0]  txn_count
`ifdef CSC_READBACK_EN
    ,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [PROD_W-1:0] rd_data
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] num_q, num_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] rot_q, rot_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              rot_sel_q, rot_sel_d;
    logic [CNT_W-1:0]  txn_q, txn_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_addr_q, out_addr_d;
    logic              we;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        key_d       = key_q;
        rot_d       = rot_q;
        prod_d      = prod_q;
        rot_sel_d   = rot_sel_q;
        txn_d       = txn_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        we          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    num_d   = num;
                    key_d   = key;
                    state_d = ROT;
                end
            end
            ROT: begin
                rot_d     = rotl_sel(num_q, rot_sel_q);
                rot_sel_d = ~rot_sel_q;
                state_d   = MUL;
            end
            MUL: begin
                prod_d  = PROD_W'(rot_q) * PROD_W'(key_q);
                state_d = WR;
            end
            WR: begin
                we          = 1'b1;
                out_valid_d = 1'b1;
                out_addr_d  = num_q;
                txn_d       = txn_q + CNT_W'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            key_q       <= '0;
            rot_q       <= '0;
            prod_q      <= '0;
            rot_sel_q   <= 1'b0;
            txn_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            key_q       <= key_d;
            rot_q       <= rot_d;
            prod_q      <= prod_d;
            rot_sel_q   <= rot_sel_d;
            txn_q       <= txn_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign txn_count = txn_q;

    // out_data views the store at the last written address, so it always
    // holds the last value written and reads 0 after a clear.
    cipher_store_mem #(
        .AW(DATA_W),
        .DW(PROD_W)
    ) u_mem (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we_i       (we),
        .waddr_i    (num_q),
        .wdata_i    (prod_q),
        .obs_addr_i (out_addr_q),
        .obs_data_o (out_data)
`ifdef CSC_READBACK_EN
        ,
        .re_i       (rd_gnt),
        .raddr_i    (rd_addr),
        .rvalid_o   (rd_valid),
        .rdata_o    (rd_data)
`endif
    );

`ifdef CSC_READBACK_EN
    assign rd_gnt = rd_req && (state_q != WR);
`endif

endmodule

// File: tb/tb_cipher_store_ctrl.sv
// Self-checking bench for cipher_store_ctrl: transaction-level model plus
// directed vectors with hand-computed results.
module tb_cipher_store_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] num;
    logic [3:0] key;
    logic       out_valid;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic [7:0] txn_count;
    logic       rd_req;
    logic [3:0] rd_addr;
`ifdef CSC_READBACK_EN
    logic       rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cipher_store_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .key       (key),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .txn_count (txn_count)
`ifdef CSC_READBACK_EN
        ,
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Transaction-level model: a job is busy for 3 edges after the
    // handshake edge, then the result appears and the store updates.
    int         busy = 0;
    logic       m_sel = 1'b0;
    logic [3:0] m_pa = '0;
    logic [7:0] m_pd = '0;
    logic       m_ov = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_data = '0;
    logic [7:0] m_cnt = '0;
    logic [7:0] m_mem [16];
    logic       m_rv = 1'b0;
    logic [7:0] m_rd = '0;
    wire        m_ready = (busy == 0);

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   = 0;
            m_sel  = 1'b0;
            m_ov   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_cnt  = '0;
            m_rv   = 1'b0;
            m_rd   = '0;
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else begin
            int k;
            int r;
            m_rv = 1'b0;
            if (rd_req && busy != 1) begin
                m_rv = 1'b1;
                m_rd = m_mem[rd_addr];
            end
            m_ov = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    m_mem[m_pa] = m_pd;
                    m_ov   = 1'b1;
                    m_addr = m_pa;
                    m_data = m_pd;
                    m_cnt  = m_cnt + 8'd1;
                end
            end else if (in_valid) begin
                k     = m_sel ? 2 : 1;
                r     = ((int'(num) << k) | (int'(num) >> (4 - k))) & 15;
                m_pd  = 8'(r * int'(key));
                m_pa  = num;
                m_sel = ~m_sel;
                busy  = 3;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_ov);
        chk("out_addr", out_addr, m_addr);
        chk("out_data", out_data, m_data);
        chk("txn_count", txn_count, m_cnt);
`ifdef CSC_READBACK_EN
        chk("rd_gnt", rd_gnt, rd_req && busy != 1);
        chk("rd_valid", rd_valid, m_rv);
        if (m_rv) chk("rd_data", rd_data, m_rd);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] n, input logic [3:0] k);
        int g = 0;
        while (!m_ready && g < 20) begin
            cyc();
            g++;
        end
        if (g >= 20) chk("send_timeout", 1, 0);
        in_valid = 1'b1;
        num      = n;
        key      = k;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [3:0] a,
                            input logic [7:0] d);
        int g = 0;
        while (!out_valid && g < 8) begin
            cyc();
            g++;
        end
        chk({nm, "_ov"}, out_valid, 1);
        chk({nm, "_addr"}, out_addr, a);
        chk({nm, "_data"}, out_data, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        in_valid = 1'b0;
        num      = '0;
        key      = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ready", in_ready, 1);
        chk("rst_ov", out_valid, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", txn_count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();

        send(4'b1000, 4'b1000);
        wait_out("t1", 4'd8, 8'h08);
        send(4'b1001, 4'b1000);
        wait_out("t2a", 4'd9, 8'h30);
        send(4'b1100, 4'b1010);
        wait_out("t2b", 4'd12, 8'h5A);
        send(4'b1011, 4'b1110);
        wait_out("t2c", 4'd11, 8'hC4);
        chk("t2_cnt", txn_count, 4);

        in_valid = 1'b1;
        key      = 4'd3;
        for (int i = 0; i < 16; i++) begin
            num = 4'(i);
            cyc();
            if (i == 0) chk("t3_busy", in_ready, 0);
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("t3_cnt", txn_count, 8);

        send(4'd3, 4'd5);
        cyc();
        #2 rst_n = 1'b0;
        cyc();
        chk("t4_cnt", txn_count, 0);
        chk("t4_ov", out_valid, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (out_valid) seen++;
        end
        chk("t4_no_ov", seen, 0);
`ifdef CSC_READBACK_EN
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            cyc();
            chk("t4_clear", rd_data, 0);
        end
        rd_req = 1'b0;
        cyc();
`endif

        send(4'b1100, 4'b1010);
        cyc();
        cyc();
        rd_req  = 1'b1;
        rd_addr = 4'd12;
`ifdef CSC_READBACK_EN
        #1 chk("t5_gnt_wr", rd_gnt, 0);
`endif
        cyc();
        chk("t4_rotl1", out_data, 8'h5A);
`ifdef CSC_READBACK_EN
        chk("t5_gnt", rd_gnt, 1);
`endif
        cyc();
        rd_req = 1'b0;
`ifdef CSC_READBACK_EN
        chk("t5_rv", rd_valid, 1);
        chk("t5_rd", rd_data, 8'h5A);
`endif

        for (int i = 0; i < 255; i++) begin
            send((i == 0 || i == 254) ? 4'd5 : 4'(i),
                 4'((i % 15) + 1));
            repeat (3) cyc();
        end
        chk("t6_wrap", txn_count, 0);
        chk("t6_last5", out_data, m_mem[5]);
`ifdef CSC_READBACK_EN
        rd_req  = 1'b1;
        rd_addr = 4'd5;
        cyc();
        rd_req = 1'b0;
        chk("t6_rd5", rd_data, m_mem[5]);
`endif
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
